// File: rtl/axi_outstanding_tracker_pkg.sv
// axi_outstanding_tracker_pkg: shared flag bundle and saturating next-count rule
package axi_outstanding_tracker_pkg;
  localparam int MAX_W = 32;
  typedef struct packed {
    logic is_zero;
    logic is_full;
    logic almost_full;
    logic overflow;
    logic underflow;
  } flags_t;
  typedef struct packed {
    logic [MAX_W-1:0] cnt;
    logic ovf;
    logic unf;
  } next_t;
  function automatic next_t next_count(input logic [MAX_W-1:0] count, input logic load,
                                       input logic [MAX_W-1:0] load_value, input logic incr,
                                       input logic decr, input logic [MAX_W-1:0] limit);
    next_t r;
    r.ovf = load ? load_value > limit : incr && !decr && count == limit;
    r.unf = !load && decr && !incr && count == '0;
    r.cnt = load ? (r.ovf ? limit : load_value) :
            (incr && !decr && !r.ovf) ? count + 1 :
            (decr && !incr && !r.unf) ? count - 1 : count;
    return r;
  endfunction
endpackage

// File: rtl/axi_outstanding_chan.sv
// axi_outstanding_chan: one saturating channel counter with flags (optional AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN)
module axi_outstanding_chan
  import axi_outstanding_tracker_pkg::*;
#(
  parameter int W         = 4,
  parameter int LIMIT     = 15,
  parameter int INIT      = 0,
  parameter int AF_MARGIN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clken,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         incr,
  input  logic         decr,
  input  logic         err_clear,
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
  input  logic         hw_clear,
  output logic [W-1:0] high_water,
`endif
  output logic [W-1:0] count,
  output flags_t       flags
);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  localparam logic [W-1:0] AF  = W'(LIMIT - AF_MARGIN);
  localparam logic [W-1:0] INI = W'(INIT);
  localparam flags_t RST_FLAGS = '{INI == '0, INI == LIM, INI >= AF, 1'b0, 1'b0};
  next_t nc;
  logic [W-1:0] nxt;
  logic unused_hi;
  // Saturating next count computed at the package's wide width, then narrowed
  always_comb begin
    nc  = next_count(MAX_W'(count), load, MAX_W'(load_value), incr, decr, MAX_W'(LIM));
    nxt = nc.cnt[W-1:0];
  end
  assign unused_hi = ^nc.cnt[MAX_W-1:W];
  // Count and flags register together so flags track count with no extra latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= INI;
      flags <= RST_FLAGS;
    end else if (clken) begin
      count <= nxt;
      flags <= '{nxt == '0, nxt == LIM, nxt >= AF,
                 nc.ovf | (flags.overflow & ~err_clear),
                 nc.unf | (flags.underflow & ~err_clear)};
    end
  end
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
  // High-water mark follows the peak next count; a clear restarts it from the next count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) high_water <= INI;
    else if (clken) high_water <= (hw_clear || nxt > high_water) ? nxt : high_water;
  end
`endif
endmodule

// File: rtl/axi_outstanding_tracker.sv
// axi_outstanding_tracker: per-channel outstanding counters (optional AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN)
module axi_outstanding_tracker
  import axi_outstanding_tracker_pkg::*;
#(
  parameter int C_NUM_CH    = 4,
  parameter int C_WIDTH     = 4,
  parameter int C_LIMIT     = 2**C_WIDTH-1,
  parameter int C_INIT      = 0,
  parameter int C_AF_MARGIN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clken,
  input  logic [C_NUM_CH-1:0]         load,
  input  logic [C_NUM_CH*C_WIDTH-1:0] load_value,
  input  logic [C_NUM_CH-1:0]         incr,
  input  logic [C_NUM_CH-1:0]         decr,
  input  logic                        err_clear,
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
  input  logic                        hw_clear,
  output logic [C_NUM_CH*C_WIDTH-1:0] high_water,
`endif
  output logic [C_NUM_CH*C_WIDTH-1:0] count,
  output logic [C_NUM_CH-1:0]         is_zero,
  output logic [C_NUM_CH-1:0]         is_full,
  output logic [C_NUM_CH-1:0]         almost_full,
  output logic                        all_zero,
  output logic [C_NUM_CH-1:0]         overflow,
  output logic [C_NUM_CH-1:0]         underflow
);
  if (C_NUM_CH < 1) begin : g_bad_ch
    $error("C_NUM_CH must be >= 1");
  end
  if (C_WIDTH < 2 || C_WIDTH >= MAX_W) begin : g_bad_w
    $error("C_WIDTH out of range");
  end
  if (C_LIMIT < 1 || C_LIMIT > 2**C_WIDTH-1) begin : g_bad_lim
    $error("C_LIMIT out of range");
  end
  if (C_INIT < 0 || C_INIT > C_LIMIT) begin : g_bad_init
    $error("C_INIT must not exceed C_LIMIT");
  end
  if (C_AF_MARGIN < 0 || C_AF_MARGIN >= C_LIMIT) begin : g_bad_af
    $error("C_AF_MARGIN must be below C_LIMIT");
  end
  flags_t fl [C_NUM_CH];
  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    axi_outstanding_chan #(
      .W(C_WIDTH), .LIMIT(C_LIMIT), .INIT(C_INIT), .AF_MARGIN(C_AF_MARGIN)
    ) u_chan (
      .clk(clk), .rst(rst), .clken(clken), .load(load[i]),
      .load_value(load_value[i*C_WIDTH +: C_WIDTH]),
      .incr(incr[i]), .decr(decr[i]), .err_clear(err_clear),
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
      .hw_clear(hw_clear), .high_water(high_water[i*C_WIDTH +: C_WIDTH]),
`endif
      .count(count[i*C_WIDTH +: C_WIDTH]), .flags(fl[i])
    );
    assign is_zero[i]     = fl[i].is_zero;
    assign is_full[i]     = fl[i].is_full;
    assign almost_full[i] = fl[i].almost_full;
    assign overflow[i]    = fl[i].overflow;
    assign underflow[i]   = fl[i].underflow;
  end
  assign all_zero = &is_zero;
endmodule

// File: tb/tb_axi_outstanding_tracker.sv
// tb_axi_outstanding_tracker: table vectors, corner sequences and random stimulus against a count model
module tb_axi_outstanding_tracker;
  localparam int N = 4, W = 4, L = 10, I = 0, M = 2;
  logic clk = 0, rst = 1, clken = 0, err_clear = 0;
  logic [N-1:0] load = '0, incr = '0, decr = '0;
  logic [N*W-1:0] load_value = '0;
  logic [N*W-1:0] count;
  logic [N-1:0] is_zero, is_full, almost_full, overflow, underflow;
  logic all_zero;
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
  logic hw_clear = 0;
  logic [N*W-1:0] high_water;
`endif
  axi_outstanding_tracker #(
    .C_NUM_CH(N), .C_WIDTH(W), .C_LIMIT(L), .C_INIT(I), .C_AF_MARGIN(M)
  ) dut (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .load_value(load_value),
    .incr(incr), .decr(decr), .err_clear(err_clear),
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
    .hw_clear(hw_clear), .high_water(high_water),
`endif
    .count(count), .is_zero(is_zero), .is_full(is_full), .almost_full(almost_full),
    .all_zero(all_zero), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;

  typedef struct {
    int ch, ld, lv, inc, dec, errc, ce;
    int e_cnt, e_ovf, e_unf, e_full, e_af;
  } vec_t;
  vec_t tbl[$];
  int checks = 0, errors = 0;
  int m_cnt[N], m_ovf[N], m_unf[N], m_hw[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = I; m_ovf[c] = 0; m_unf[c] = 0; m_hw[c] = I;
    end
  endtask

  task automatic model_step();
    if (!clken) return;
    for (int c = 0; c < N; c++) begin
      int lv, so, su;
      lv = int'(load_value[c*W +: W]); so = 0; su = 0;
      if (load[c]) begin
        so = int'(lv > L);
        m_cnt[c] = lv > L ? L : lv;
      end else if (incr[c] && !decr[c]) begin
        if (m_cnt[c] == L) so = 1; else m_cnt[c]++;
      end else if (decr[c] && !incr[c]) begin
        if (m_cnt[c] == 0) su = 1; else m_cnt[c]--;
      end
      m_ovf[c] = int'(so != 0 || (m_ovf[c] != 0 && !err_clear));
      m_unf[c] = int'(su != 0 || (m_unf[c] != 0 && !err_clear));
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
      m_hw[c] = (hw_clear || m_cnt[c] > m_hw[c]) ? m_cnt[c] : m_hw[c];
`endif
    end
  endtask

  task automatic check_all();
    int az;
    az = 1;
    for (int c = 0; c < N; c++) begin
      chk($sformatf("count%0d", c), 32'(count[c*W +: W]), m_cnt[c]);
      chk($sformatf("is_zero%0d", c), 32'(is_zero[c]), int'(m_cnt[c] == 0));
      chk($sformatf("is_full%0d", c), 32'(is_full[c]), int'(m_cnt[c] == L));
      chk($sformatf("almost_full%0d", c), 32'(almost_full[c]), int'(m_cnt[c] >= L - M));
      chk($sformatf("overflow%0d", c), 32'(overflow[c]), m_ovf[c]);
      chk($sformatf("underflow%0d", c), 32'(underflow[c]), m_unf[c]);
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
      chk($sformatf("high_water%0d", c), 32'(high_water[c*W +: W]), m_hw[c]);
`endif
      if (m_cnt[c] != 0) az = 0;
    end
    chk("all_zero", 32'(all_zero), az);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic idle();
    load = '0; incr = '0; decr = '0; load_value = '0; err_clear = 0; clken = 1;
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
    hw_clear = 0;
`endif
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] lv;
    idle();
    lv = 32'(v.lv);
    load[v.ch] = v.ld[0];
    load_value[v.ch*W +: W] = lv[W-1:0];
    incr[v.ch] = v.inc[0];
    decr[v.ch] = v.dec[0];
    err_clear = v.errc[0];
    clken = v.ce[0];
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 0;
    idle();
    for (int i = 1; i <= 10; i++) tbl.push_back('{0, 0, 0, 1, 0, 0, 1, i, 0, 0, int'(i == 10), int'(i >= 8)});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1, 10, 1, 0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{2, 1, 15, 0, 0, 0, 1, 10, 1, 0, 1, 1});
    tbl.push_back('{2, 1, 3, 1, 0, 0, 1, 3, 1, 0, 0, 0});
    tbl.push_back('{3, 1, 5, 0, 0, 0, 1, 5, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++) tbl.push_back('{3, 0, 0, 1, 1, 0, 1, 5, 0, 0, 0, 0});
    tbl.push_back('{3, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0});
    foreach (tbl[k]) begin
      apply(tbl[k]);
      cyc();
      chk($sformatf("tbl%0d_cnt", k), 32'(count[tbl[k].ch*W +: W]), tbl[k].e_cnt);
      chk($sformatf("tbl%0d_ovf", k), 32'(overflow[tbl[k].ch]), tbl[k].e_ovf);
      chk($sformatf("tbl%0d_unf", k), 32'(underflow[tbl[k].ch]), tbl[k].e_unf);
      chk($sformatf("tbl%0d_full", k), 32'(is_full[tbl[k].ch]), tbl[k].e_full);
      chk($sformatf("tbl%0d_af", k), 32'(almost_full[tbl[k].ch]), tbl[k].e_af);
    end
    idle();
    chk("ch0_overflow_after_tbl", 32'(overflow[0]), 0);
    load = '1;
    load_value = {4'd3, 4'd5, 4'd7, 4'd9};
    cyc();
    idle();
    chk("all_zero_before_async", 32'(all_zero), 0);
    @(negedge clk);
    #2 rst = 1;
    #1 model_reset();
    check_all();
    chk("async_count_all", 32'(count), 0);
    @(negedge clk);
    rst = 0;
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
    incr[0] = 1;
    repeat (7) cyc();
    incr[0] = 0;
    decr[0] = 1;
    repeat (5) cyc();
    decr[0] = 0;
    chk("hw0_peak", 32'(high_water[0 +: W]), 7);
    hw_clear = 1;
    cyc();
    hw_clear = 0;
    chk("hw0_cleared", 32'(high_water[0 +: W]), 2);
`endif
    for (int k = 0; k < 400; k++) begin
      load = N'($urandom & $urandom & $urandom);
      load_value = (N*W)'($urandom);
      incr = N'($urandom);
      decr = N'($urandom);
      err_clear = ($urandom_range(0, 15) == 0);
      clken = ($urandom_range(0, 7) != 0);
`ifdef AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN
      hw_clear = ($urandom_range(0, 15) == 0);
`endif
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_outstanding_tracker.md
Name: axi_outstanding_tracker

Overview:
- Multi-channel AXI outstanding-transaction tracker.
- One saturating up/down counter per channel, e.g. per AXI ID or per read/write port.
- Counters are bounded by a programmable limit. Each channel has registered zero/full/almost-full flags and sticky overflow/underflow error flags.
- Sits beside AXI master engines to throttle issue (use is_full) and to detect drain (use all_zero).

Parameters:
- C_NUM_CH, 4: number of independent channels (>=1).
- C_WIDTH, 4: counter width in bits (>=2).
- C_LIMIT, 2**C_WIDTH-1: maximum outstanding count per channel. Must satisfy 1 <= C_LIMIT <= 2**C_WIDTH-1.
- C_INIT, 0: reset/initial count for every channel. Must satisfy C_INIT <= C_LIMIT.
- C_AF_MARGIN, 1: almost_full asserts when count >= C_LIMIT-C_AF_MARGIN. Must satisfy C_AF_MARGIN < C_LIMIT.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-high.
- clken  in  1  global clock enable; when low, all state holds.
- load  in  C_NUM_CH  per-channel load strobe.
- load_value  in  C_NUM_CH*C_WIDTH  per-channel load data, channel i at [i*C_WIDTH +: C_WIDTH].
- incr  in  C_NUM_CH  per-channel increment (transaction issued).
- decr  in  C_NUM_CH  per-channel decrement (transaction completed).
- err_clear  in  1  clears all sticky error flags.
- count  out  C_NUM_CH*C_WIDTH  current per-channel counts.
- is_zero  out  C_NUM_CH  count==0, registered.
- is_full  out  C_NUM_CH  count==C_LIMIT, registered.
- almost_full  out  C_NUM_CH  count>=C_LIMIT-C_AF_MARGIN, registered.
- all_zero  out  1  AND of is_zero (combinational from registers).
- overflow  out  C_NUM_CH  sticky: an increment or load was attempted beyond C_LIMIT.
- underflow  out  C_NUM_CH  sticky: a decrement was attempted at zero.

Behaviour:
- Reset (asynchronous assert, synchronous deassert supplied externally):
  - count=C_INIT.
  - is_zero=(C_INIT==0), is_full=(C_INIT==C_LIMIT), almost_full per the rule above.
  - overflow=0, underflow=0.
- Channels are fully independent. All updates occur on the rising clk edge with clken=1. With clken=0, every register holds, including the error flags; err_clear is ignored.
- Per-channel priority: load > incr/decr.
- load:
  - Next count = min(load_value, C_LIMIT).
  - If load_value > C_LIMIT, overflow sets.
  - incr/decr are ignored in the same cycle.
- incr=1, decr=1 together: count unchanged, no error.
- incr only:
  - count<C_LIMIT: count+1.
  - count==C_LIMIT: count holds and overflow sets. It never wraps.
- decr only:
  - count>0: count-1.
  - count==0: count holds and underflow sets. It never wraps.
- Flags are computed from the next count and registered on the same edge. They are therefore valid the same cycle count changes, with zero additional latency versus count.
- err_clear=1 clears overflow/underflow on all channels. If a new error occurs on a channel in the same cycle, set wins for that channel.
- Arithmetic is unsigned, C_WIDTH bits. Comparisons against C_LIMIT use C_WIDTH-bit constants.
- Parameter violations are elaboration errors, raised with $error in a generate check.

Optional Feature:
- Macro AXI_OUTSTANDING_TRACKER_HIGH_WATER_EN.
- When defined, the block adds:
  - Output high_water (C_NUM_CH*C_WIDTH): per-channel maximum count reached since reset or the last clear. Reset value C_INIT. Updated as max(high_water, next count).
  - Input hw_clear (1): when hw_clear=1, high_water loads the next count. Gated by clken.
- When undefined, neither port nor its logic exists, and the port list is exactly as above.

Decomposition:
- Package axi_outstanding_tracker_pkg holds:
  - typedef for the flag bundle struct (is_zero, is_full, almost_full, overflow, underflow).
  - function next_count(count, load, load_value, incr, decr, limit), which returns the next count plus ovf/unf bits.
- Sub-module axi_outstanding_chan: one channel (counter, flags, sticky errors, optional high-water). The top generates C_NUM_CH instances and the all_zero reduction.

Test Plan (C_NUM_CH=4, C_WIDTH=4, C_LIMIT=10, C_INIT=0, C_AF_MARGIN=2):
1. Reset, then 10 incr on ch0 -> count0 steps 1..10; almost_full0 rises with count0=8; is_full0=1 at 10. Then 1 more incr -> count0 stays 10, overflow0=1; all_zero=0.
2. From 0, decr on ch1 -> count1=0, underflow1=1. Then err_clear together with another decr on ch1 -> underflow1 stays 1. Then err_clear alone -> underflow1=0.
3. ch2 load_value=15 -> count2=10, overflow2=1, is_full2=1. Then load_value=3 with incr=1 in the same cycle -> count2=3 (load wins).
4. ch3 count=5, incr=decr=1 for 4 cycles -> count3 stays 5, no errors. Then clken=0 with incr=1 -> count3 stays 5.
5. Assert rst asynchronously mid-clock while all channels are non-zero -> all counts go to 0 immediately without a clock edge; flags clear; all_zero=1.
6. (HIGH_WATER_EN) ch0 goes to 7, then decrements to 2 -> high_water0=7. hw_clear -> high_water0=2.
